alu_muldiv_seq: RTL and testbench

ALU_MULDIV_SEQ -- requirements
Module: alu_muldiv_seq

---
 rtl/alu_muldiv_seq_pkg.sv | 36 +++
 rtl/muldiv_step.sv | 52 +++++
 rtl/alu_muldiv_seq.sv | 121 ++++++++++++
 tb/tb_alu_muldiv_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_seq_pkg.sv
// Shared ALU function codes and sequencer state encodings.
// Used by the multiply/divide sequencer and by the ALU decoder.
package alu_muldiv_seq_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SOLT = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Reference behaviour of the shared ALU for a given function code.
  function automatic logic [31:0] alu_eval(input logic [3:0] ctl,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (ctl)
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_SOLT: r = {31'd0, $signed(a) < $signed(b)};
      ALU_NOR:  r = ~(a | b);
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One shift-add (MULTU) or restoring shift-subtract (DIVU) iteration.
// Purely combinational; the adder/subtractor lives in the shared ALU.
module muldiv_step
  import alu_muldiv_seq_pkg::*;
(
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic [31:0] opnd,
  input  logic        div,
  input  logic [31:0] alu_result,
  output logic [31:0] next_hi,
  output logic [31:0] next_lo,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [3:0]  alu_control
);

  logic [31:0] rem;
  logic        top;
  logic        carry;

  always_comb begin
    rem         = {hi[30:0], lo[31]};
    top         = hi[31];
    carry       = 1'b0;
    alu_op1     = hi;
    alu_op2     = opnd;
    alu_control = ALU_ADD;
    next_hi     = hi;
    next_lo     = lo;
    if (div) begin
      alu_op1     = rem;
      alu_control = ALU_SUB;
      // A set top bit means the 33-bit partial remainder already exceeds any divisor.
      if (top || (rem >= opnd)) begin
        next_hi = alu_result;
        next_lo = {lo[30:0], 1'b1};
      end else begin
        next_hi = rem;
        next_lo = {lo[30:0], 1'b0};
      end
    end else begin
      carry = (alu_result < hi);
      if (lo[0]) begin
        {next_hi, next_lo} = {carry, alu_result, lo[31:1]};
      end else begin
        {next_hi, next_lo} = {1'b0, hi, lo[31:1]};
      end
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// 32-iteration MULTU/DIVU sequencer borrowing the shared ALU while busy.
// Divide-by-zero short-circuits straight to DONE with HI=dividend, LO=all ones.
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_div,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output logic [31:0] o_alu_op1,
  output logic [31:0] o_alu_op2,
  output logic [3:0]  o_alu_control,
  input  logic [31:0] i_alu_result,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_dz,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic        div_q;
  logic        dz_q;
  logic [31:0] hi_q, lo_q, opnd_q;
  logic [31:0] step_hi, step_lo, step_op1, step_op2;
  logic [3:0]  step_ctl;
  logic        dz_start;

  assign dz_start = i_div && (i_rt == 32'd0);

  muldiv_step u_step (
    .hi          (hi_q),
    .lo          (lo_q),
    .opnd        (opnd_q),
    .div         (div_q),
    .alu_result  (i_alu_result),
    .next_hi     (step_hi),
    .next_lo     (step_lo),
    .alu_op1     (step_op1),
    .alu_op2     (step_op2),
    .alu_control (step_ctl)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    o_busy        = 1'b0;
    o_done        = 1'b0;
    o_dz          = 1'b0;
    o_alu_op1     = 32'd0;
    o_alu_op2     = 32'd0;
    o_alu_control = ALU_AND;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = dz_start ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        o_busy        = 1'b1;
        o_alu_op1     = step_op1;
        o_alu_op2     = step_op2;
        o_alu_control = step_ctl;
        if (cnt_q == 5'd31) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        o_busy  = 1'b1;
        o_done  = 1'b1;
        o_dz    = dz_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= 5'd0;
      div_q  <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      opnd_q <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            div_q  <= i_div;
            opnd_q <= i_rt;
            cnt_q  <= 5'd0;
            dz_q   <= dz_start;
            hi_q   <= dz_start ? i_rs : 32'd0;
            lo_q   <= dz_start ? 32'hFFFF_FFFF : i_rs;
          end
        end
        ST_RUN: begin
          hi_q  <= step_hi;
          lo_q  <= step_lo;
          cnt_q <= cnt_q + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_hi = hi_q;
  assign o_lo = lo_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with an independent model of the shared ALU.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        div = 1'b0;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic [3:0]  alu_control;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_div         (div),
    .i_rs          (rs),
    .i_rt          (rt),
    .o_alu_op1     (alu_op1),
    .o_alu_op2     (alu_op2),
    .o_alu_control (alu_control),
    .i_alu_result  (alu_result),
    .o_busy        (busy),
    .o_done        (done),
    .o_dz          (dz),
    .o_hi          (hi),
    .o_lo          (lo)
  );

  always_comb begin
    alu_result = 32'd0;
    case (alu_control)
      4'b0000: alu_result = alu_op1 & alu_op2;
      4'b0001: alu_result = alu_op1 | alu_op2;
      4'b0010: alu_result = alu_op1 + alu_op2;
      4'b0110: alu_result = alu_op1 - alu_op2;
      4'b0111: alu_result = {31'd0, $signed(alu_op1) < $signed(alu_op2)};
      4'b1100: alu_result = ~(alu_op1 | alu_op2);
      default: alu_result = 32'd0;
    endcase
  end

  // Starts one operation and watches 41 cycles; cycle 1 is the one right after the sampling edge.
  task automatic run_op(input logic d, input logic [31:0] a, input logic [31:0] b,
                        input int pulse_at,
                        output int dcyc, output int ndone,
                        output logic [31:0] rhi, output logic [31:0] rlo,
                        output logic rdz, output logic [3:0] rctl);
    dcyc = -1; ndone = 0; rhi = '0; rlo = '0; rdz = 1'b0; rctl = '0;
    @(negedge clk);
    start = 1'b1; div = d; rs = a; rt = b;
    @(posedge clk); #1;
    start = 1'b0; rs = 32'hDEAD_BEEF; rt = 32'h0BAD_0BAD;
    for (int k = 0; k < 41; k++) begin
      if (k == 1) rctl = alu_control;
      if (done) begin
        ndone++;
        if (dcyc < 0) begin
          dcyc = k + 1; rhi = hi; rlo = lo; rdz = dz;
        end
      end
      if (k == pulse_at) begin
        start = 1'b1; div = 1'b1; rs = 32'd100; rt = 32'd7;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL reset_dz got=%b exp=0", dz); end
    checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo got=%h_%h exp=0", hi, lo); end
    checks++; if ({alu_op1, alu_op2, alu_control} !== 68'd0) begin
      errors++; $display("FAIL reset_alu got=%h %h %h exp=0", alu_op1, alu_op2, alu_control); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_multu();
    int c, n; logic [31:0] h, l; logic z; logic [3:0] ctl;
    run_op(1'b0, 32'd3, 32'd5, -1, c, n, h, l, z, ctl);
    checks++; if (c !== 33) begin errors++; $display("FAIL mul3x5_cycle got=%0d exp=33", c); end
    checks++; if ({h, l} !== 64'd15) begin errors++; $display("FAIL mul3x5_res got=%h_%h exp=0_f", h, l); end
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL mul3x5_dz got=%b exp=0", z); end
    checks++; if (ctl !== 4'b0010) begin errors++; $display("FAIL mul_aluctl got=%h exp=2", ctl); end
    checks++; if (n !== 1) begin errors++; $display("FAIL mul3x5_ndone got=%0d exp=1", n); end
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, c, n, h, l, z, ctl);
    checks++; if ({h, l} !== 64'hFFFF_FFFE_0000_0001) begin
      errors++; $display("FAIL mul_max got=%h_%h exp=fffffffe_00000001", h, l); end
    run_op(1'b0, 32'h1234_5678, 32'h10, -1, c, n, h, l, z, ctl);
    checks++; if ({h, l} !== 64'h0000_0001_2345_6780) begin
      errors++; $display("FAIL mul_shift got=%h_%h exp=00000001_23456780", h, l); end
    checks++; if ({alu_op1, alu_op2, alu_control} !== 68'd0) begin
      errors++; $display("FAIL idle_alu got=%h %h %h exp=0", alu_op1, alu_op2, alu_control); end
  endtask

  task automatic test_divu();
    int c, n; logic [31:0] h, l; logic z; logic [3:0] ctl;
    run_op(1'b1, 32'd100, 32'd7, -1, c, n, h, l, z, ctl);
    checks++; if (c !== 33) begin errors++; $display("FAIL div100_7_cycle got=%0d exp=33", c); end
    checks++; if (l !== 32'd14 || h !== 32'd2) begin
      errors++; $display("FAIL div100_7 got=q%0d r%0d exp=q14 r2", l, h); end
    checks++; if (ctl !== 4'b0110) begin errors++; $display("FAIL div_aluctl got=%h exp=6", ctl); end
    run_op(1'b1, 32'hFFFF_FFFF, 32'd1, -1, c, n, h, l, z, ctl);
    checks++; if (l !== 32'hFFFF_FFFF || h !== 32'd0) begin
      errors++; $display("FAIL div_by1 got=q%h r%h exp=qffffffff r0", l, h); end
    run_op(1'b1, 32'h8000_0000, 32'd3, -1, c, n, h, l, z, ctl);
    checks++; if (l !== 32'h2AAA_AAAA || h !== 32'd2) begin
      errors++; $display("FAIL div_by3 got=q%h r%h exp=q2aaaaaaa r2", l, h); end
    run_op(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, -1, c, n, h, l, z, ctl);
    checks++; if (l !== 32'd1 || h !== 32'h7FFF_FFFE) begin
      errors++; $display("FAIL div_big got=q%h r%h exp=q1 r7ffffffe", l, h); end
  endtask

  task automatic test_div_zero();
    int c, n; logic [31:0] h, l; logic z; logic [3:0] ctl;
    run_op(1'b1, 32'd1234, 32'd0, -1, c, n, h, l, z, ctl);
    checks++; if (c !== 1) begin errors++; $display("FAIL dz_cycle got=%0d exp=1", c); end
    checks++; if (z !== 1'b1) begin errors++; $display("FAIL dz_flag got=%b exp=1", z); end
    checks++; if (h !== 32'd1234 || l !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL dz_res got=%h_%h exp=000004d2_ffffffff", h, l); end
    checks++; if (n !== 1) begin errors++; $display("FAIL dz_ndone got=%0d exp=1", n); end
    checks++; if (hi !== 32'd1234 || dz !== 1'b0) begin
      errors++; $display("FAIL dz_hold got=hi%h dz%b exp=hi000004d2 dz0", hi, dz); end
  endtask

  task automatic test_start_in_run();
    int c, n; logic [31:0] h, l; logic z; logic [3:0] ctl;
    run_op(1'b0, 32'd3, 32'd5, 4, c, n, h, l, z, ctl);
    checks++; if ({h, l} !== 64'd15) begin errors++; $display("FAIL ign_start_res got=%h_%h exp=0_f", h, l); end
    checks++; if (n !== 1) begin errors++; $display("FAIL ign_start_ndone got=%0d exp=1", n); end
    checks++; if (c !== 33) begin errors++; $display("FAIL ign_start_cycle got=%0d exp=33", c); end
  endtask

  task automatic test_reset_in_run();
    int c, n, seen; logic [31:0] h, l; logic z; logic [3:0] ctl;
    seen = 0;
    @(negedge clk);
    start = 1'b1; div = 1'b0; rs = 32'd7; rt = 32'd9;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 1; k < 10; k++) begin @(posedge clk); #1; end
    rst_n = 1'b0; #1;
    checks++; if ({busy, done, dz} !== 3'b000) begin
      errors++; $display("FAIL rst_run_flags got=%b%b%b exp=000", busy, done, dz); end
    checks++; if ({hi, lo} !== 64'd0 || {alu_op1, alu_op2, alu_control} !== 68'd0) begin
      errors++; $display("FAIL rst_run_data got=%h_%h alu %h %h %h exp=0", hi, lo, alu_op1, alu_op2, alu_control); end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin @(posedge clk); #1; if (done) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_run_nodone got=%0d exp=0", seen); end
    run_op(1'b0, 32'd2, 32'd2, -1, c, n, h, l, z, ctl);
    checks++; if ({h, l} !== 64'd4 || c !== 33) begin
      errors++; $display("FAIL rst_then_mul got=%h_%h cyc%0d exp=0_4 cyc33", h, l, c); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_divu();
    test_div_zero();
    test_start_in_run();
    test_reset_in_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
